// File: rtl/ucaspian_pkg.sv
// Shared types and default sizing for the uCaspian core control blocks.
package ucaspian_pkg;

    localparam int unsigned UC_NUM_UNITS = 3;
    localparam int unsigned UC_STEPS_W   = 16;
    localparam int unsigned UC_TIME_W    = 32;
    localparam int unsigned UC_SETTLE    = 2;

    typedef enum logic [1:0] {
        CMD_NOP       = 2'd0,
        CMD_CLEAR_ACT = 2'd1,
        CMD_CLEAR_CFG = 2'd2,
        CMD_RUN       = 2'd3
    } cmd_op_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STEP   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_WAIT   = 3'd4,
        ST_FINISH = 3'd5
    } step_ctrl_state_t;

endpackage

// File: rtl/ucaspian_step_ctrl.sv
// Timestep sequencer: turns host clear/run commands into clear and next_step
// controls for the neuron, axon and synapse units and tracks global time.
module ucaspian_step_ctrl
    import ucaspian_pkg::*;
#(
    parameter int unsigned NUM_UNITS = UC_NUM_UNITS,
    parameter int unsigned STEPS_W   = UC_STEPS_W,
    parameter int unsigned TIME_W    = UC_TIME_W,
    parameter int unsigned SETTLE    = UC_SETTLE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [1:0]           cmd_op,
    input  logic [STEPS_W-1:0]   cmd_steps,
    input  logic                 cmd_vld,
    output logic                 cmd_rdy,
    input  logic                 abort,
    output logic                 clear_act,
    output logic                 clear_config,
    input  logic [NUM_UNITS-1:0] clear_done,
    output logic                 next_step,
    input  logic [NUM_UNITS-1:0] step_done,
    output logic [TIME_W-1:0]    cur_time,
    output logic [STEPS_W-1:0]   steps_left,
    output logic                 busy,
    output logic                 cmd_done
);

    localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

    step_ctrl_state_t   state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               abort_q, abort_d;
    logic               first_q, first_d;
    logic               cfg_q, cfg_d;
    logic               cmd_rdy_q, cmd_rdy_d;
    logic               clear_act_q, clear_act_d;
    logic               clear_config_q, clear_config_d;
    logic               next_step_q, next_step_d;
    logic [TIME_W-1:0]  cur_time_q, cur_time_d;
    logic [STEPS_W-1:0] steps_left_q, steps_left_d;
    logic               busy_q, busy_d;
    logic               cmd_done_q, cmd_done_d;
    logic               abort_pend;

    // A same-cycle abort counts as well as a previously latched one.
    assign abort_pend = abort_q | abort;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        abort_d        = abort_q;
        first_d        = first_q;
        cfg_d          = cfg_q;
        clear_act_d    = clear_act_q;
        clear_config_d = clear_config_q;
        next_step_d    = 1'b0;
        cur_time_d     = cur_time_q;
        steps_left_d   = steps_left_q;
        cmd_done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                abort_d = 1'b0;
                if (cmd_vld && cmd_rdy_q) begin
                    case (cmd_op_t'(cmd_op))
                        CMD_CLEAR_ACT: begin
                            state_d     = ST_CLEAR;
                            clear_act_d = 1'b1;
                            cfg_d       = 1'b0;
                            first_d     = 1'b1;
                        end
                        CMD_CLEAR_CFG: begin
                            state_d        = ST_CLEAR;
                            clear_config_d = 1'b1;
                            cfg_d          = 1'b1;
                            first_d        = 1'b1;
                        end
                        CMD_RUN: begin
                            steps_left_d = cmd_steps;
                            state_d      = (cmd_steps == '0) ? ST_FINISH : ST_STEP;
                        end
                        default: ;
                    endcase
                end
            end

            // clear_done in the first cycle still reflects the previous operation.
            ST_CLEAR: begin
                abort_d = 1'b0;
                first_d = 1'b0;
                if (!first_q && (&clear_done)) begin
                    clear_act_d    = 1'b0;
                    clear_config_d = 1'b0;
                    state_d        = ST_FINISH;
                    if (cfg_q) begin
                        cur_time_d = '0;
                    end
                end
            end

            ST_STEP: begin
                abort_d = abort_pend;
                if (enable) begin
                    next_step_d = 1'b1;
                    cnt_d       = CNT_W'(SETTLE);
                    state_d     = (SETTLE == 0) ? ST_WAIT : ST_SETTLE;
                end
            end

            // Unit step_done is stale here; only the countdown matters.
            ST_SETTLE: begin
                abort_d = abort_pend;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                abort_d = abort_pend;
                if (&step_done) begin
                    cur_time_d   = cur_time_q + TIME_W'(1);
                    steps_left_d = steps_left_q - STEPS_W'(1);
                    state_d      = (steps_left_q == STEPS_W'(1) || abort_pend) ? ST_FINISH : ST_STEP;
                end
            end

            ST_FINISH: begin
                cmd_done_d = 1'b1;
                abort_d    = 1'b0;
                state_d    = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d    = (state_d != ST_IDLE);
        cmd_rdy_d = (state_d == ST_IDLE) && enable;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            abort_q        <= 1'b0;
            first_q        <= 1'b0;
            cfg_q          <= 1'b0;
            cmd_rdy_q      <= enable;
            clear_act_q    <= 1'b0;
            clear_config_q <= 1'b0;
            next_step_q    <= 1'b0;
            cur_time_q     <= '0;
            steps_left_q   <= '0;
            busy_q         <= 1'b0;
            cmd_done_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            abort_q        <= abort_d;
            first_q        <= first_d;
            cfg_q          <= cfg_d;
            cmd_rdy_q      <= cmd_rdy_d;
            clear_act_q    <= clear_act_d;
            clear_config_q <= clear_config_d;
            next_step_q    <= next_step_d;
            cur_time_q     <= cur_time_d;
            steps_left_q   <= steps_left_d;
            busy_q         <= busy_d;
            cmd_done_q     <= cmd_done_d;
        end
    end

    assign cmd_rdy      = cmd_rdy_q;
    assign clear_act    = clear_act_q;
    assign clear_config = clear_config_q;
    assign next_step    = next_step_q;
    assign cur_time     = cur_time_q;
    assign steps_left   = steps_left_q;
    assign busy         = busy_q;
    assign cmd_done     = cmd_done_q;

endmodule
